mem_port_arbiter: RTL and testbench

//  Parametrised N-requester front-end for the single unified memory. Replaces direct

---
 rtl/mem_pkg.sv | 56 +++++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared definitions for the unified-memory port arbiter:
//            RV32 load/store funct3 codes, arbiter FSM state type and
//            byte-lane helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

   // RV32 load/store funct3 encodings (store uses the signed codes)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   // Legal funct3 for the direction, with the natural alignment satisfied.
   // Unsigned codes exist only for loads.
   function automatic logic lane_ok(input logic [2:0] funct3,
                                    input logic [1:0] b,
                                    input logic       write);
      logic ok;
      case (funct3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~b[0];
         F3_W:    ok = (b == 2'b00);
         F3_BU:   ok = ~write;
         F3_HU:   ok = ~write & ~b[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Byte-lane write mask for a store of the given size at lane b.
   function automatic logic [3:0] lane_strb(input logic [2:0] funct3,
                                            input logic [1:0] b);
      logic [3:0] s;
      case (funct3)
         F3_B:    s = 4'b0001 << b;
         F3_H:    s = 4'b0011 << b;
         F3_W:    s = 4'b1111;
         default: s = 4'b0000;
      endcase
      return s;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick. Grants the first asserted
//            request at or above ptr, wrapping to the lowest asserted one.
// Ports    : req   in  N_REQ  request vector
//            ptr   in  PW     priority pointer (0..N_REQ-1)
//            grant out N_REQ  one-hot grant, zero when no request
//            idx   out PW     index of the granted request
//            any   out 1      at least one request asserted
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
   parameter int N_REQ = 2,
   parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] grant,
   output logic [PW-1:0]    idx,
   output logic             any
);

   logic          hi_any;
   logic          lo_any;
   logic [PW-1:0] hi_idx;
   logic [PW-1:0] lo_idx;

   // Scan downward so the last hit is the lowest index: lo_* is the lowest
   // request overall, hi_* the lowest at or above the pointer.
   always_comb begin
      hi_any = 1'b0;
      lo_any = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_any = 1'b1;
            lo_idx = PW'(i);
            if (PW'(i) >= ptr) begin
               hi_any = 1'b1;
               hi_idx = PW'(i);
            end
         end
      end
   end

   assign any   = lo_any;
   assign idx   = hi_any ? hi_idx : lo_idx;
   assign grant = lo_any ? (N_REQ'(1) << idx) : '0;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : N-requester front-end for the single unified memory. Round-robin
//            arbitration, one transaction outstanding, RV32 byte/half/word
//            lane handling, load extension and misalignment trapping.
// Ports    : clk, rst_n             clock, async active-low reset
//            req_valid/ready        per-channel request handshake
//            req_write/addr/wdata/funct3  per-channel request fields (packed)
//            rsp_valid              one-cycle pulse to the owning channel
//            rsp_err, rsp_rdata     response qualifiers / load result
//            mem_en/we/addr/wdata/wstrb  memory access (one-cycle strobe)
//            mem_rdata              read word, MEM_LAT cycles after mem_en
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
   import mem_pkg::*;
#(
   parameter int N_REQ   = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_REQ-1:0]  req_valid,
   output logic [N_REQ-1:0]  req_ready,
   input  logic [N_REQ-1:0]  req_write,
   input  logic [N_REQ*AW-1:0] req_addr,
   input  logic [N_REQ*DW-1:0] req_wdata,
   input  logic [N_REQ*3-1:0]  req_funct3,
   output logic [N_REQ-1:0]  rsp_valid,
   output logic              rsp_err,
   output logic [DW-1:0]     rsp_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic [DW-1:0]     mem_rdata
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CW = 3;   // holds MEM_LAT-1 for MEM_LAT up to 7

   state_t        state;
   state_t        state_nxt;

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] owner;
   logic [N_REQ-1:0] arb_grant;
   logic [PW-1:0] arb_idx;
   logic          arb_any;

   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic [2:0]    sel_f3;
   logic          sel_write;
   logic          sel_ok;

   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic [2:0]    f3_q;
   logic          write_q;
   logic          err_q;
   logic [CW-1:0] cnt;
   logic [DW-1:0] rdata_q;

   logic [DW-1:0] rd_shift;
   logic [DW-1:0] load_ext;

   rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   // Fields of the granted channel
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_f3    = '0;
      sel_write = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_grant[i]) begin
            sel_addr  = req_addr[i*AW +: AW];
            sel_wdata = req_wdata[i*DW +: DW];
            sel_f3    = req_funct3[i*3 +: 3];
            sel_write = req_write[i];
         end
      end
      sel_ok = lane_ok(sel_f3, sel_addr[1:0], sel_write);
   end

   // Load result: bring the addressed lane down to bit 0, then extend.
   always_comb begin
      rd_shift = mem_rdata >> {addr_q[1:0], 3'b000};
      load_ext = '0;
      case (f3_q)
         F3_B:    load_ext = {{(DW-8){rd_shift[7]}},   rd_shift[7:0]};
         F3_H:    load_ext = {{(DW-16){rd_shift[15]}}, rd_shift[15:0]};
         F3_W:    load_ext = rd_shift;
         F3_BU:   load_ext = {{(DW-8){1'b0}},  rd_shift[7:0]};
         F3_HU:   load_ext = {{(DW-16){1'b0}}, rd_shift[15:0]};
         default: load_ext = '0;
      endcase
   end

   // State register and transaction context
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         owner   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         f3_q    <= '0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         cnt     <= '0;
         rdata_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (arb_any) begin
                  owner   <= arb_idx;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
                  f3_q    <= sel_f3;
                  write_q <= sel_write;
                  err_q   <= ~sel_ok;
                  rdata_q <= '0;   // stores and errors return zero
               end
            end
            ACCESS: cnt <= CW'(MEM_LAT - 1);
            WAIT: begin
               if (cnt == '0) begin
                  rdata_q <= load_ext;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RESP: rr_ptr <= (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);
            default: ;
         endcase
      end
   end

   // Next state. Loads always spend at least one cycle in WAIT so that
   // mem_rdata is sampled exactly MEM_LAT cycles after mem_en.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (arb_any) state_nxt = sel_ok ? ACCESS : RESP;
         ACCESS:  state_nxt = write_q ? RESP : WAIT;
         WAIT:    if (cnt == '0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are pure functions of state/context so that everything is zero
   // while reset is held; req_ready is additionally gated by rst_n because
   // it is combinational from req_valid.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      rsp_err   = 1'b0;
      rsp_rdata = '0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = 4'b0000;
      case (state)
         IDLE: begin
            if (rst_n) req_ready = arb_grant;
         end
         ACCESS: begin
            mem_en   = 1'b1;
            mem_we   = write_q;
            mem_addr = {addr_q[AW-1:2], 2'b00};
            if (write_q) begin
               mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
               mem_wstrb = lane_strb(f3_q, addr_q[1:0]);
            end
         end
         RESP: begin
            rsp_valid = N_REQ'(1) << owner;
            rsp_err   = err_q;
            rsp_rdata = rdata_q;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. Two instances:
//            index 0 with MEM_LAT=1, index 1 with MEM_LAT=3, each with its
//            own small byte-lane memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

   logic clk;
   logic rst_n;

   logic [1:0]  req_valid  [2];
   logic [1:0]  req_write  [2];
   logic [63:0] req_addr   [2];
   logic [63:0] req_wdata  [2];
   logic [5:0]  req_funct3 [2];

   logic [1:0]  rdy1, rv1, rdy3, rv3;
   logic        err1, en1, we1, err3, en3, we3;
   logic [31:0] rd1, ma1, mwd1, mrd1, rd3, ma3, mwd3, mrd3;
   logic [3:0]  ws1, ws3;

   int n_pass;
   int n_total;

   mem_port_arbiter #(.N_REQ(2), .AW(32), .DW(32), .MEM_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(rdy1), .req_write(req_write[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
      .rsp_valid(rv1), .rsp_err(err1), .rsp_rdata(rd1),
      .mem_en(en1), .mem_we(we1), .mem_addr(ma1), .mem_wdata(mwd1),
      .mem_wstrb(ws1), .mem_rdata(mrd1)
   );

   mem_port_arbiter #(.N_REQ(2), .AW(32), .DW(32), .MEM_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(rdy3), .req_write(req_write[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
      .rsp_valid(rv3), .rsp_err(err3), .rsp_rdata(rd3),
      .mem_en(en3), .mem_we(we3), .mem_addr(ma3), .mem_wdata(mwd3),
      .mem_wstrb(ws3), .mem_rdata(mrd3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- memory models ----------------
   logic [31:0] mem1 [64];
   logic [31:0] mem3 [64];
   logic [31:0] p0, p1;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] st);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (st[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   // Read data is only meaningful in the exact cycle; any other cycle sees a
   // filler pattern.
   always @(posedge clk) begin
      if (en1 && we1) mem1[ma1[7:2]] <= merge(mem1[ma1[7:2]], mwd1, ws1);
      mrd1 <= (en1 && !we1) ? mem1[ma1[7:2]] : 32'h5A5A5A5A;
   end

   always @(posedge clk) begin
      if (en3 && we3) mem3[ma3[7:2]] <= merge(mem3[ma3[7:2]], mwd3, ws3);
      p0   <= (en3 && !we3) ? mem3[ma3[7:2]] : 32'h5A5A5A5A;
      p1   <= p0;
      mrd3 <= p1;
   end

   // ---------------- memory-side monitor ----------------
   int          en_cnt1, en_cnt3;
   logic [31:0] l_addr1, l_wdata1;
   logic [3:0]  l_wstrb1;
   logic        l_we1;

   always @(negedge clk) begin
      if (en1) begin
         en_cnt1  <= en_cnt1 + 1;
         l_addr1  <= ma1;
         l_wdata1 <= mwd1;
         l_wstrb1 <= ws1;
         l_we1    <= we1;
      end
      if (en3) en_cnt3 <= en_cnt3 + 1;
   end

   function automatic logic [1:0] ready_of(input int d);
      return (d == 0) ? rdy1 : rdy3;
   endfunction
   function automatic logic [1:0] rv_of(input int d);
      return (d == 0) ? rv1 : rv3;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // One request on channel ch of instance d; returns cycles from the
   // req_ready cycle to rsp_valid, the response and the mem_en count.
   task automatic run_txn(input int d, input int ch, input logic wr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] f3,
                          output int lat, output logic [1:0] rv, output logic [1:0] rv_after,
                          output logic err, output logic [31:0] rdata,
                          output int n_en, output logic tmo);
      int         en0;
      int         w;
      logic [1:0] r;
      tmo = 1'b0; lat = 0; rv = '0; rv_after = '0; err = 1'b0; rdata = '0; n_en = 0;
      @(negedge clk);
      req_write[d][ch]        = wr;
      req_addr[d][ch*32 +: 32] = addr;
      req_wdata[d][ch*32 +: 32] = wdata;
      req_funct3[d][ch*3 +: 3]  = f3;
      req_valid[d][ch]        = 1'b1;
      en0 = (d == 0) ? en_cnt1 : en_cnt3;
      w = 0;
      #1;
      r = ready_of(d);
      while (r[ch] == 1'b0 && w < 20) begin
         @(negedge clk); #1; w++;
         r = ready_of(d);
      end
      if (r[ch] == 1'b0) begin
         tmo = 1'b1;
         req_valid[d][ch] = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid[d][ch] = 1'b0;
      lat = 1;
      rv  = rv_of(d);
      while (rv == 2'b00 && lat < 20) begin
         @(negedge clk); lat++;
         rv = rv_of(d);
      end
      err   = (d == 0) ? err1 : err3;
      rdata = (d == 0) ? rd1 : rd3;
      @(negedge clk); #1;
      rv_after = rv_of(d);
      n_en = ((d == 0) ? en_cnt1 : en_cnt3) - en0;
   endtask

   typedef struct {
      int          ch;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      int          lat;
      logic        err;
      logic [31:0] rdata;
      int          n_en;
      logic [31:0] maddr;
      logic [3:0]  wstrb;
      logic [31:0] mwdata;
   } vec_t;

   vec_t vecs [21];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int          lat, n_en;
      logic [1:0]  rv, rv_after;
      logic        err, tmo;
      logic [31:0] rdata;
      logic [1:0]  got [4];
      logic [1:0]  exp_g [4];
      int          k, w;
      logic        seen;

      n_pass = 0; n_total = 0;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = '0; req_write[d] = '0; req_addr[d] = '0;
         req_wdata[d] = '0; req_funct3[d] = '0;
      end

      //            ch wr    addr    wdata          f3   lat err rdata         en maddr   wstrb   mwdata
      vecs[0]  = '{0, 1'b1, 32'h10, 32'hDEADBEEF, F_W,  2, 1'b0, 32'h0,        1, 32'h10, 4'hF,    32'hDEADBEEF};
      vecs[1]  = '{1, 1'b1, 32'h10, 32'h80347F55, F_W,  2, 1'b0, 32'h0,        1, 32'h10, 4'hF,    32'h80347F55};
      vecs[2]  = '{1, 1'b0, 32'h13, 32'h0,        F_B,  3, 1'b0, 32'hFFFFFF80, 1, 32'h10, 4'h0,    32'h0};
      vecs[3]  = '{1, 1'b0, 32'h13, 32'h0,        F_BU, 3, 1'b0, 32'h00000080, 1, 32'h10, 4'h0,    32'h0};
      vecs[4]  = '{0, 1'b0, 32'h12, 32'h0,        F_H,  3, 1'b0, 32'hFFFF8034, 1, 32'h10, 4'h0,    32'h0};
      vecs[5]  = '{0, 1'b0, 32'h12, 32'h0,        F_HU, 3, 1'b0, 32'h00008034, 1, 32'h10, 4'h0,    32'h0};
      vecs[6]  = '{1, 1'b0, 32'h11, 32'h0,        F_B,  3, 1'b0, 32'h0000007F, 1, 32'h10, 4'h0,    32'h0};
      vecs[7]  = '{0, 1'b0, 32'h10, 32'h0,        F_B,  3, 1'b0, 32'h00000055, 1, 32'h10, 4'h0,    32'h0};
      vecs[8]  = '{0, 1'b0, 32'h10, 32'h0,        F_W,  3, 1'b0, 32'h80347F55, 1, 32'h10, 4'h0,    32'h0};
      vecs[9]  = '{0, 1'b1, 32'h21, 32'h1234,     F_H,  1, 1'b1, 32'h0,        0, 32'h0,  4'h0,    32'h0};
      vecs[10] = '{1, 1'b1, 32'h31, 32'hAB,       F_B,  2, 1'b0, 32'h0,        1, 32'h30, 4'b0010, 32'h0000AB00};
      vecs[11] = '{0, 1'b1, 32'h32, 32'hCD,       F_B,  2, 1'b0, 32'h0,        1, 32'h30, 4'b0100, 32'h00CD0000};
      vecs[12] = '{1, 1'b0, 32'h31, 32'h0,        F_BU, 3, 1'b0, 32'h000000AB, 1, 32'h30, 4'h0,    32'h0};
      vecs[13] = '{1, 1'b1, 32'h32, 32'hBEEF,     F_H,  2, 1'b0, 32'h0,        1, 32'h30, 4'b1100, 32'hBEEF0000};
      vecs[14] = '{0, 1'b0, 32'h32, 32'h0,        F_H,  3, 1'b0, 32'hFFFFBEEF, 1, 32'h30, 4'h0,    32'h0};
      vecs[15] = '{0, 1'b1, 32'h40, 32'h1,        F_BU, 1, 1'b1, 32'h0,        0, 32'h0,  4'h0,    32'h0};
      vecs[16] = '{1, 1'b0, 32'h40, 32'h0,        3'b011, 1, 1'b1, 32'h0,      0, 32'h0,  4'h0,    32'h0};
      vecs[17] = '{1, 1'b0, 32'h42, 32'h0,        F_W,  1, 1'b1, 32'h0,        0, 32'h0,  4'h0,    32'h0};
      vecs[18] = '{0, 1'b0, 32'h40, 32'h0,        3'b110, 1, 1'b1, 32'h0,      0, 32'h0,  4'h0,    32'h0};
      vecs[19] = '{1, 1'b0, 32'h13, 32'h0,        F_H,  1, 1'b1, 32'h0,        0, 32'h0,  4'h0,    32'h0};
      vecs[20] = '{0, 1'b0, 32'h33, 32'h0,        F_B,  3, 1'b0, 32'hFFFFFFBE, 1, 32'h30, 4'h0,    32'h0};

      // ---- reset state (requests pending while in reset must not be granted)
      rst_n = 1'b0;
      req_valid[0] = 2'b11;
      req_valid[1] = 2'b11;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs_lat1", {rdy1, rv1, err1, rd1, en1, we1, ma1, mwd1, ws1}, '0);
      check("reset_outputs_lat3", {rdy3, rv3, err3, rd3, en3, we3, ma3, mwd3, ws3}, '0);
      req_valid[0] = 2'b00;
      req_valid[1] = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // ---- table-driven single transactions on the MEM_LAT=1 instance
      for (int i = 0; i < 21; i++) begin
         run_txn(0, vecs[i].ch, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].f3,
                 lat, rv, rv_after, err, rdata, n_en, tmo);
         check($sformatf("v%0d_ready", i), 128'(tmo), 128'(0));
         check($sformatf("v%0d_latency", i), 128'(lat), 128'(vecs[i].lat));
         check($sformatf("v%0d_rsp_channel", i), 128'(rv), 128'(2'b01 << vecs[i].ch));
         check($sformatf("v%0d_rsp_one_cycle", i), 128'(rv_after), 128'(0));
         check($sformatf("v%0d_rsp_err", i), 128'(err), 128'(vecs[i].err));
         check($sformatf("v%0d_rsp_rdata", i), 128'(rdata), 128'(vecs[i].rdata));
         check($sformatf("v%0d_mem_en_count", i), 128'(n_en), 128'(vecs[i].n_en));
         if (vecs[i].n_en == 1) begin
            check($sformatf("v%0d_mem_addr", i), 128'(l_addr1), 128'(vecs[i].maddr));
            check($sformatf("v%0d_mem_we", i), 128'(l_we1), 128'(vecs[i].wr));
            check($sformatf("v%0d_mem_wstrb", i), 128'(l_wstrb1), 128'(vecs[i].wstrb));
            check($sformatf("v%0d_mem_wdata", i), 128'(l_wdata1), 128'(vecs[i].mwdata));
         end
      end

      // ---- round-robin: both channels valid continuously from a fresh pointer
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      req_addr[0]   = {32'h10, 32'h10};
      req_funct3[0] = {F_W, F_W};
      req_write[0]  = 2'b00;
      req_valid[0]  = 2'b11;
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
      for (int i = 0; i < 4; i++) got[i] = 2'b00;
      k = 0; w = 0;
      while (k < 4 && w < 60) begin
         #1;
         if (rdy1 != 2'b00) begin
            got[k] = rdy1;
            k++;
         end
         @(negedge clk);
         w++;
      end
      req_valid[0] = 2'b00;
      for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), 128'(got[i]), 128'(exp_g[i]));
      repeat (6) @(negedge clk);

      // ---- MEM_LAT=3 instance: store then load
      run_txn(1, 0, 1'b1, 32'h50, 32'hCAFEF00D, F_W, lat, rv, rv_after, err, rdata, n_en, tmo);
      check("lat3_store_latency", 128'(lat), 128'(2));
      check("lat3_store_channel", 128'(rv), 128'(2'b01));
      run_txn(1, 1, 1'b0, 32'h50, 32'h0, F_W, lat, rv, rv_after, err, rdata, n_en, tmo);
      check("lat3_load_latency", 128'(lat), 128'(5));
      check("lat3_load_channel", 128'(rv), 128'(2'b10));
      check("lat3_load_rdata", 128'(rdata), 128'(32'hCAFEF00D));
      check("lat3_load_mem_en_count", 128'(n_en), 128'(1));

      // ---- reset asserted while a load sits in WAIT
      @(negedge clk);
      req_addr[1][31:0]  = 32'h50;
      req_funct3[1][2:0] = F_W;
      req_write[1][0]    = 1'b0;
      req_valid[1][0]    = 1'b1;
      w = 0;
      #1;
      while (rdy3[0] == 1'b0 && w < 20) begin
         @(negedge clk); #1; w++;
      end
      check("abort_ready", 128'(rdy3[0]), 128'(1));
      @(negedge clk);            // ACCESS
      req_valid[1][0] = 1'b0;
      @(negedge clk);            // WAIT
      rst_n = 1'b0;
      #1;
      check("abort_outputs_zero", {rdy3, rv3, err3, rd3, en3, we3, ma3, mwd3, ws3}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rv3 != 2'b00 || en3) seen = 1'b1;
      end
      check("abort_no_response", 128'(seen), 128'(0));

      // ---- instance still operational after the abort
      run_txn(1, 0, 1'b0, 32'h52, 32'h0, F_HU, lat, rv, rv_after, err, rdata, n_en, tmo);
      check("post_abort_latency", 128'(lat), 128'(5));
      check("post_abort_rdata", 128'(rdata), 128'(32'h0000CAFE));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
